usb_packet_tx: RTL and testbench

USB low/full-speed packet transmitter that serializes one packet per request onto a D+/D- pair. It takes a PID and a payload, then emits SYNC, PID, payload, CRC5/CRC16 and EOP, with bit stuffing and NRZI encoding applied. It is the transmit counterpart of the proxy's sniffing receive path. It drives either the host-side or the device-side pins through `tx_oe` when the design injects its own handshakes, tokens or short data packets.

---
 rtl/usb_packet_tx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_usb_packet_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_tx.sv
// USB LS/FS packet transmitter: SYNC, PID, token/data payload, CRC5/CRC16, EOP,
// with bit stuffing and NRZI encoding on a D+/D- pair.
module usb_packet_tx #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_fs,
   input  logic        start,
   input  logic [1:0]  kind,
   input  logic [3:0]  pid,
   input  logic [63:0] data,
   input  logic [3:0]  len,
   output logic        tx_dp,
   output logic        tx_dm,
   output logic        tx_oe,
   output logic        busy,
   output logic        done
);

   localparam int unsigned TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned IW = 6;

   localparam logic [1:0] KIND_HS  = 2'd0;
   localparam logic [1:0] KIND_TOK = 2'd1;
   localparam logic [1:0] KIND_RSV = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_SYNC, S_PID, S_TOK, S_DAT, S_CRC16, S_EOP, S_JBIT, S_FIN
   } state_t;

   state_t          state_q, state_nxt;
   logic [IW-1:0]   idx_q, idx_nxt;
   logic [TW-1:0]   timer_q, timer_nxt;
   logic [2:0]      ones_q, ones_nxt;
   logic [4:0]      crc5_q, crc5_nxt;
   logic [15:0]     crc16_q, crc16_nxt;
   logic            line_k_q, line_k_nxt;
   logic            se0_q, se0_nxt;
   logic            fs_q, fs_nxt;
   logic [1:0]      kind_q, kind_nxt;
   logic [3:0]      pid_q, pid_nxt;
   logic [63:0]     data_q, data_nxt;
   logic [3:0]      len_q, len_nxt;
   logic            busy_q, busy_nxt;
   logic            oe_q, oe_nxt;
   logic            done_q, done_nxt;

   logic [7:0]      pid_byte;
   logic            pol;

   assign pid_byte = {~pid_q, pid_q};
   // Idle line follows the live polarity input; a packet uses the latched one.
   assign pol      = (state_q == S_IDLE) ? is_fs : fs_q;
   assign tx_dp    = se0_q ? 1'b0 : (pol ^ line_k_q);
   assign tx_dm    = se0_q ? 1'b0 : ~(pol ^ line_k_q);
   assign tx_oe    = oe_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         timer_q  <= '0;
         ones_q   <= '0;
         crc5_q   <= '0;
         crc16_q  <= '0;
         line_k_q <= 1'b0;
         se0_q    <= 1'b0;
         fs_q     <= 1'b0;
         kind_q   <= '0;
         pid_q    <= '0;
         data_q   <= '0;
         len_q    <= '0;
         busy_q   <= 1'b0;
         oe_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         idx_q    <= idx_nxt;
         timer_q  <= timer_nxt;
         ones_q   <= ones_nxt;
         crc5_q   <= crc5_nxt;
         crc16_q  <= crc16_nxt;
         line_k_q <= line_k_nxt;
         se0_q    <= se0_nxt;
         fs_q     <= fs_nxt;
         kind_q   <= kind_nxt;
         pid_q    <= pid_nxt;
         data_q   <= data_nxt;
         len_q    <= len_nxt;
         busy_q   <= busy_nxt;
         oe_q     <= oe_nxt;
         done_q   <= done_nxt;
      end
   end

   state_t phase;
   logic   boundary;
   logic   send;
   logic   dbit;
   logic   fb;
   logic   dat_last;

   assign dat_last = ({1'b0, idx_q} == ({len_q, 3'b000} - 7'd1));

   // Next-state: input latch, bit timer, per-bit sequencing, stuffing, NRZI
   always_comb begin
      state_nxt  = state_q;
      idx_nxt    = idx_q;
      timer_nxt  = timer_q;
      ones_nxt   = ones_q;
      crc5_nxt   = crc5_q;
      crc16_nxt  = crc16_q;
      line_k_nxt = line_k_q;
      se0_nxt    = se0_q;
      fs_nxt     = fs_q;
      kind_nxt   = kind_q;
      pid_nxt    = pid_q;
      data_nxt   = data_q;
      len_nxt    = len_q;
      busy_nxt   = busy_q;
      oe_nxt     = oe_q;
      done_nxt   = 1'b0;
      phase      = state_q;
      boundary   = 1'b0;
      send       = 1'b0;
      dbit       = 1'b1;
      fb         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && kind != KIND_RSV) begin
               fs_nxt    = is_fs;
               kind_nxt  = kind;
               pid_nxt   = pid;
               data_nxt  = data;
               len_nxt   = (len > 4'd8) ? 4'd8 : len;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            boundary  = 1'b1;
            phase     = S_SYNC;
            busy_nxt  = 1'b1;
            oe_nxt    = 1'b1;
            timer_nxt = '0;
            idx_nxt   = '0;
            crc5_nxt  = 5'h1F;
            crc16_nxt = 16'hFFFF;
         end
         default: begin
            if (timer_q == TW'(CLK_DIV - 1)) begin
               timer_nxt = '0;
               boundary  = 1'b1;
            end else begin
               timer_nxt = timer_q + TW'(1);
            end
         end
      endcase

      if (boundary) begin
         if (ones_q == 3'd6) begin
            line_k_nxt = ~line_k_q;
            ones_nxt   = '0;
         end else begin
            state_nxt = phase;
            idx_nxt   = idx_q + IW'(1);
            send      = 1'b1;
            case (phase)
               S_SYNC: begin
                  dbit = (idx_q == IW'(7));
                  if (idx_q == IW'(7)) begin
                     state_nxt = S_PID;
                     idx_nxt   = '0;
                  end
               end
               S_PID: begin
                  dbit = pid_byte[idx_q[2:0]];
                  if (idx_q == IW'(7)) begin
                     idx_nxt = '0;
                     if (kind_q == KIND_HS)       state_nxt = S_EOP;
                     else if (kind_q == KIND_TOK) state_nxt = S_TOK;
                     else if (len_q == 4'd0)      state_nxt = S_CRC16;
                     else                         state_nxt = S_DAT;
                  end
               end
               S_TOK: begin
                  if (idx_q < IW'(11)) begin
                     dbit     = data_q[idx_q];
                     fb       = dbit ^ crc5_q[4];
                     crc5_nxt = {crc5_q[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
                  end else begin
                     dbit     = ~crc5_q[4];
                     crc5_nxt = {crc5_q[3:0], 1'b0};
                  end
                  if (idx_q == IW'(15)) begin
                     state_nxt = S_EOP;
                     idx_nxt   = '0;
                  end
               end
               S_DAT: begin
                  dbit      = data_q[idx_q];
                  fb        = dbit ^ crc16_q[15];
                  crc16_nxt = {crc16_q[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                  if (dat_last) begin
                     state_nxt = S_CRC16;
                     idx_nxt   = '0;
                  end
               end
               S_CRC16: begin
                  dbit      = ~crc16_q[15];
                  crc16_nxt = {crc16_q[14:0], 1'b0};
                  if (idx_q == IW'(15)) begin
                     state_nxt = S_EOP;
                     idx_nxt   = '0;
                  end
               end
               S_EOP: begin
                  send    = 1'b0;
                  se0_nxt = 1'b1;
                  if (idx_q == IW'(1)) begin
                     state_nxt = S_JBIT;
                     idx_nxt   = '0;
                  end
               end
               S_JBIT: begin
                  send       = 1'b0;
                  se0_nxt    = 1'b0;
                  line_k_nxt = 1'b0;
                  state_nxt  = S_FIN;
                  idx_nxt    = '0;
               end
               S_FIN: begin
                  send      = 1'b0;
                  state_nxt = S_IDLE;
                  idx_nxt   = '0;
                  ones_nxt  = '0;
                  busy_nxt  = 1'b0;
                  oe_nxt    = 1'b0;
                  done_nxt  = 1'b1;
               end
               default: begin
                  send      = 1'b0;
                  state_nxt = S_IDLE;
               end
            endcase

            // NRZI: a zero toggles the line; ones extend the stuffing run
            if (send) begin
               if (dbit) begin
                  ones_nxt = ones_q + 3'd1;
               end else begin
                  ones_nxt   = '0;
                  line_k_nxt = ~line_k_q;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Self-checking bench for usb_packet_tx: directed table plus randomized packets
// compared cycle by cycle against a bit-list reference model.
module tb_usb_packet_tx;

   localparam int CD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_fs;
   logic        start;
   logic [1:0]  kind;
   logic [3:0]  pid;
   logic [63:0] data;
   logic [3:0]  len;
   logic        tx_dp, tx_dm, tx_oe, busy, done;

   int checks = 0;
   int errors = 0;
   int exp_sym[$];   // 0 = J, 1 = K, 2 = SE0, one entry per bit time

   usb_packet_tx #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .is_fs(is_fs), .start(start), .kind(kind),
      .pid(pid), .data(data), .len(len), .tx_dp(tx_dp), .tx_dm(tx_dm),
      .tx_oe(tx_oe), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] lvl(input int s, input bit fs);
      case (s)
         0:       return {fs, ~fs};
         1:       return {~fs, fs};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [7:0] outs();
      return {3'b000, done, busy, tx_oe, tx_dp, tx_dm};
   endfunction

   // Reference: unstuffed bit list -> stuffed list -> NRZI line symbols + EOP + J
   task automatic build(input logic [1:0] k, input logic [3:0] p,
                        input logic [63:0] d, input logic [3:0] l);
      bit b[$];
      bit s[$];
      logic [7:0]  pb;
      logic [4:0]  c5;
      logic [15:0] c16;
      bit x, f;
      int ones, lv, nbytes;
      b = {};
      s = {};
      for (int i = 0; i < 7; i++) b.push_back(1'b0);
      b.push_back(1'b1);
      pb = {~p, p};
      for (int i = 0; i < 8; i++) b.push_back(pb[i]);
      if (k == 2'd1) begin
         c5 = 5'h1F;
         for (int i = 0; i < 11; i++) begin
            x = d[i];
            b.push_back(x);
            f = x ^ c5[4];
            c5 = {c5[3:0], 1'b0} ^ (f ? 5'h05 : 5'h00);
         end
         for (int i = 4; i >= 0; i--) b.push_back(~c5[i]);
      end else if (k == 2'd2) begin
         nbytes = (l > 4'd8) ? 8 : int'(l);
         c16 = 16'hFFFF;
         for (int i = 0; i < nbytes * 8; i++) begin
            x = d[i];
            b.push_back(x);
            f = x ^ c16[15];
            c16 = {c16[14:0], 1'b0} ^ (f ? 16'h8005 : 16'h0000);
         end
         for (int i = 15; i >= 0; i--) b.push_back(~c16[i]);
      end
      ones = 0;
      foreach (b[i]) begin
         s.push_back(b[i]);
         ones = b[i] ? ones + 1 : 0;
         if (ones == 6) begin
            s.push_back(1'b0);
            ones = 0;
         end
      end
      exp_sym = {};
      lv = 0;
      foreach (s[i]) begin
         if (!s[i]) lv = 1 - lv;
         exp_sym.push_back(lv);
      end
      exp_sym.push_back(2);
      exp_sym.push_back(2);
      exp_sym.push_back(0);
   endtask

   // One packet; n_bits > 0 fixes the bit-time count, else the model's length is used
   task automatic run_pkt(input string nm, input bit fs, input logic [1:0] k,
                          input logic [3:0] p, input logic [63:0] d, input logic [3:0] l,
                          input int n_bits, input bit poke, input bit hold);
      int total, s, bi;
      build(k, p, d, l);
      total = (n_bits > 0) ? n_bits : exp_sym.size();
      is_fs = fs; kind = k; pid = p; data = d; len = l; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin
         start = 1'b0;
         is_fs = 1'($urandom); kind = 2'($urandom); pid = 4'($urandom);
         data = {$urandom, $urandom}; len = 4'($urandom);
      end
      chk({nm, "_load"}, outs(), {3'b000, 3'b000, lvl(0, fs)});
      for (int c = 0; c < total * CD; c++) begin
         @(posedge clk); #1;
         bi = c / CD;
         s  = (bi < exp_sym.size()) ? exp_sym[bi] : 0;
         chk($sformatf("%s_c%0d", nm, c), outs(), {3'b000, 3'b011, lvl(s, fs)});
         if (poke && c == 37) begin
            start = 1'b1;
            kind  = 2'($urandom);
         end
         if (poke && c == 38) start = 1'b0;
      end
      @(posedge clk); #1;
      chk({nm, "_done"}, outs(), {3'b000, 3'b100, lvl(0, is_fs)});
   endtask

   typedef struct {
      string       nm;
      bit          fs;
      logic [1:0]  kind;
      logic [3:0]  pid;
      logic [63:0] data;
      logic [3:0]  len;
      int          n;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int seen;
      vecs[0] = '{"ack",    1'b1, 2'd0, 4'b0010, 64'h0,  4'd0,  19};
      vecs[1] = '{"setup",  1'b1, 2'd1, 4'b1101, 64'h0,  4'd0,  35};
      vecs[2] = '{"data0z", 1'b1, 2'd2, 4'b0011, 64'h0,  4'd0,  35};
      vecs[3] = '{"dataff", 1'b1, 2'd2, 4'b0011, 64'hFF, 4'd1,  45};
      vecs[4] = '{"nak_ls", 1'b0, 2'd0, 4'b1010, 64'h0,  4'd0,  19};
      vecs[5] = '{"clamp",  1'b1, 2'd2, 4'b1011, 64'h0,  4'd15, 0};

      rst = 1'b0; is_fs = 1'b1; start = 1'b0; kind = '0; pid = '0; data = '0; len = '0;
      #1;
      chk("reset_fs", outs(), 8'b0000_0010);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i])
         run_pkt(vecs[i].nm, vecs[i].fs, vecs[i].kind, vecs[i].pid, vecs[i].data,
                 vecs[i].len, vecs[i].n, 1'b0, 1'b0);

      // Reserved kind never starts a packet
      kind = 2'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (busy || done || tx_oe) seen++;
      end
      chk("kind3_ignored", 8'(seen), 8'd0);

      // Start pulsed mid-packet must not disturb the packet in flight
      run_pkt("poke", 1'b1, 2'd2, 4'b0011, 64'h0123_4567_89AB_CDEF, 4'd8, 0, 1'b1, 1'b0);

      // Reset in the middle of the PID, LS polarity
      is_fs = 1'b0; kind = 2'd0; pid = 4'b0010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (1 + CD * 10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_mid_async", outs(), 8'b0000_0001);
      @(posedge clk); #1;
      chk("rst_mid_hold", outs(), 8'b0000_0001);
      rst = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done || busy) seen++;
      end
      chk("rst_no_done", 8'(seen), 8'd0);
      run_pkt("after_rst", 1'b0, 2'd0, 4'b0010, 64'h0, 4'd0, 19, 1'b0, 1'b0);

      // Start held through done is accepted only on the next idle cycle
      run_pkt("hold", 1'b1, 2'd0, 4'b0010, 64'h0, 4'd0, 19, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk("hold_reload", outs(), {3'b000, 3'b000, lvl(0, 1'b1)});
      @(posedge clk); #1;
      chk("hold_restart", outs(), {3'b000, 3'b011, lvl(1, 1'b1)});
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && seen == 0; c++) begin
         @(posedge clk); #1;
         if (done) seen = 1;
      end
      chk("hold_second_done", 8'(seen), 8'd1);
      @(posedge clk); #1;

      for (int r = 0; r < 30; r++) begin
         run_pkt($sformatf("rnd%0d", r), 1'($urandom), 2'($urandom_range(0, 2)),
                 4'($urandom), {$urandom, $urandom}, 4'($urandom),
                 0, 1'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
